// File: rtl/lifo_arb_pkg.sv
// lifo_arb_pkg: shared constants, FSM encoding and arbitration helper for lifo_arb.
// Optional macro LIFO_ARB_FIXED_PRIO_EN selects fixed priority in the top.
package lifo_arb_pkg;

  localparam int unsigned LIFO_DW    = 8;
  localparam int unsigned LIFO_DEPTH = 16;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Round-robin winner: on a tie the requester that did not win last time.
  function automatic logic rr_pick(input logic [1:0] req, input logic last);
    return (req == 2'b11) ? ~last : req[1];
  endfunction

endpackage

// File: rtl/lifo_arb_if.sv
// lifo_arb_if: requester-side bus of lifo_arb.
//   req/op/wdata0/wdata1 : requests from the datapath (master drives)
//   gnt/rvalid/rdata/err : completion signals from the arbiter (slave drives)
//   full/empty           : stack status from the arbiter
interface lifo_arb_if #(
  parameter int unsigned DW = 8
) ();

  logic [1:0]    req;
  logic [1:0]    op;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic [1:0]    gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;
  logic          err;
  logic          full;
  logic          empty;

  modport master (
    output req, op, wdata0, wdata1,
    input  gnt, rvalid, rdata, err, full, empty
  );

  modport slave (
    input  req, op, wdata0, wdata1,
    output gnt, rvalid, rdata, err, full, empty
  );

endinterface

// File: rtl/lifo_core.sv
// lifo_core: DEPTH x DW stack storage with an AW+1 bit pointer.
//   clk, rst_n     : clock, async active-low reset (pointer only)
//   push_i, pop_i  : one-cycle operation strobes (ignored when full/empty)
//   din_i          : push data
//   dout_o_c       : top-of-stack entry mem[ptr-1], combinational
//   full_o_c       : ptr == DEPTH, combinational
//   empty_o_c      : ptr == 0, combinational
module lifo_core #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_o_c,
  output logic          full_o_c,
  output logic          empty_o_c
);

  localparam int unsigned PW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] top_idx;

  assign full_o_c  = (ptr_q == PW'(DEPTH));
  assign empty_o_c = (ptr_q == PW'(0));
  assign top_idx   = AW'(ptr_q - PW'(1));
  assign dout_o_c  = mem_q[top_idx];

  // Pointer next state; illegal operations leave it unchanged.
  always_comb begin
    ptr_d = ptr_q;
    if (push_i && !full_o_c) begin
      ptr_d = ptr_q + PW'(1);
    end else if (pop_i && !empty_o_c) begin
      ptr_d = ptr_q - PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_i && !full_o_c) begin
      mem_q[ptr_q[AW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/lifo_arb.sv
// lifo_arb: two-requester arbiter/sequencer in front of lifo_core.
//   clk    : clock, rising edge
//   resetn : async active-low reset
//   bus    : lifo_arb_if slave (req/op/wdata in, gnt/rvalid/rdata/err/full/empty out)
// Macro LIFO_ARB_FIXED_PRIO_EN: requester 0 always wins ties (default round-robin).
module lifo_arb
  import lifo_arb_pkg::*;
#(
  parameter int unsigned DW    = LIFO_DW,
  parameter int unsigned DEPTH = LIFO_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       resetn,
  lifo_arb_if.slave  bus
);

  state_e        state_q, state_d;
  logic          win_q, win_d;
  logic          op_q, op_d;
  logic [DW-1:0] data_q, data_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          rvalid_q, rvalid_d;
  logic          err_q, err_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          pick_c;
  logic          push_c, pop_c;
  logic [DW-1:0] dout_c;
  logic          full_c, empty_c;

`ifdef LIFO_ARB_FIXED_PRIO_EN
  assign pick_c = ~bus.req[0];
`else
  logic rr_last_q, rr_last_d;
  assign pick_c = rr_pick(bus.req, rr_last_q);
`endif

  lifo_core #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_core (
    .clk       (clk),
    .rst_n     (resetn),
    .push_i    (push_c),
    .pop_i     (pop_c),
    .din_i     (data_q),
    .dout_o_c  (dout_c),
    .full_o_c  (full_c),
    .empty_o_c (empty_c)
  );

  // Next-state and registered-output logic; completion outputs are one-cycle pulses.
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    op_d      = op_q;
    data_d    = data_q;
`ifndef LIFO_ARB_FIXED_PRIO_EN
    rr_last_d = rr_last_q;
`endif
    gnt_d     = 2'b00;
    rvalid_d  = 1'b0;
    err_d     = 1'b0;
    rdata_d   = rdata_q;
    push_c    = 1'b0;
    pop_c     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req != 2'b00) begin
          win_d   = pick_c;
          op_d    = bus.op[pick_c];
          data_d  = pick_c ? bus.wdata1 : bus.wdata0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        gnt_d = win_q ? 2'b10 : 2'b01;
        if (op_q == OP_PUSH) begin
          push_c = 1'b1;
          err_d  = full_c;
        end else begin
          pop_c = 1'b1;
          if (empty_c) begin
            err_d = 1'b1;
          end else begin
            rvalid_d = 1'b1;
            rdata_d  = dout_c;
          end
        end
        state_d = S_DONE;
      end
      S_DONE: begin
`ifndef LIFO_ARB_FIXED_PRIO_EN
        rr_last_d = win_q;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      win_q     <= 1'b0;
      op_q      <= OP_PUSH;
      data_q    <= '0;
`ifndef LIFO_ARB_FIXED_PRIO_EN
      rr_last_q <= 1'b1;
`endif
      gnt_q     <= 2'b00;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      op_q      <= op_d;
      data_q    <= data_d;
`ifndef LIFO_ARB_FIXED_PRIO_EN
      rr_last_q <= rr_last_d;
`endif
      gnt_q     <= gnt_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.rvalid = rvalid_q;
  assign bus.err    = err_q;
  assign bus.rdata  = rdata_q;
  assign bus.full   = full_c;
  assign bus.empty  = empty_c;

endmodule

// File: tb/tb_lifo_arb.sv
// tb_lifo_arb: directed plus randomized bench for lifo_arb with a queue-based reference model.
module tb_lifo_arb;

  localparam int DEPTH = 16;

  logic clk;
  logic resetn;
  lifo_arb_if #(.DW(8)) bus ();

  lifo_arb dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a transaction starts on an idle edge with any request,
  // completes (gnt etc. visible) after the following edge, and frees the
  // block one edge later.
  logic [7:0] stk[$];
  int         busy;
  bit         m_win, m_op, m_last;
  logic [7:0] m_data;
  logic [1:0] exp_gnt;
  logic       exp_rvalid, exp_err;
  logic [7:0] exp_rdata;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stk.delete();
      busy       = 0;
      m_last     = 1'b1;
      exp_gnt    = 2'b00;
      exp_rvalid = 1'b0;
      exp_err    = 1'b0;
      exp_rdata  = 8'h00;
    end else begin
      exp_gnt    = 2'b00;
      exp_rvalid = 1'b0;
      exp_err    = 1'b0;
      if (busy == 2) begin
        exp_gnt = m_win ? 2'b10 : 2'b01;
        if (m_op == 1'b0) begin
          if (stk.size() == DEPTH) exp_err = 1'b1;
          else stk.push_back(m_data);
        end else begin
          if (stk.size() == 0) exp_err = 1'b1;
          else begin
            exp_rdata  = stk.pop_back();
            exp_rvalid = 1'b1;
          end
        end
        busy = 1;
      end else if (busy == 1) begin
        m_last = m_win;
        busy   = 0;
      end else if (bus.req != 2'b00) begin
`ifdef LIFO_ARB_FIXED_PRIO_EN
        m_win = bus.req[0] ? 1'b0 : 1'b1;
`else
        if (bus.req == 2'b11) m_win = !m_last;
        else m_win = bus.req[1];
`endif
        m_op   = bus.op[m_win];
        m_data = m_win ? bus.wdata1 : bus.wdata0;
        busy   = 2;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (resetn) begin
      chk("gnt",    32'(bus.gnt),    32'(exp_gnt));
      chk("rvalid", 32'(bus.rvalid), 32'(exp_rvalid));
      chk("err",    32'(bus.err),    32'(exp_err));
      chk("rdata",  32'(bus.rdata),  32'(exp_rdata));
      chk("full",   32'(bus.full),   32'(stk.size() == DEPTH));
      chk("empty",  32'(bus.empty),  32'(stk.size() == 0));
    end
  end

  // One transaction from requester i; returns the completion outputs and the
  // number of negedges waited after the request was raised.
  task automatic do_txn(input int i, input bit o, input logic [7:0] d,
                        output logic [1:0] g, output logic rv, output logic er,
                        output logic [7:0] rd, output int lat);
    bit seen;
    seen = 1'b0;
    lat  = -1;
    @(negedge clk);
    bus.req[i] = 1'b1;
    bus.op[i]  = o;
    if (i == 0) bus.wdata0 = d;
    else        bus.wdata1 = d;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.gnt != 2'b00) begin
        seen = 1'b1;
        lat  = k;
        break;
      end
    end
    g  = bus.gnt;
    rv = bus.rvalid;
    er = bus.err;
    rd = bus.rdata;
    bus.req[i] = 1'b0;
    if (!seen) chk("txn_timeout", 32'd0, 32'd1);
  endtask

  logic [1:0] g;
  logic       rv, er;
  logic [7:0] rd;
  int         lat;
  logic [7:0] pushed [4];

  initial begin
    bus.req    = 2'b00;
    bus.op     = 2'b00;
    bus.wdata0 = 8'h00;
    bus.wdata1 = 8'h00;
    resetn     = 1'b0;
    #1;
    chk("rst_gnt",    32'(bus.gnt),    32'd0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst_err",    32'(bus.err),    32'd0);
    chk("rst_rdata",  32'(bus.rdata),  32'd0);
    chk("rst_full",   32'(bus.full),   32'd0);
    chk("rst_empty",  32'(bus.empty),  32'd1);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // Single push then pop from the other requester.
    do_txn(0, 1'b0, 8'hA5, g, rv, er, rd, lat);
    chk("t1_gnt", 32'(g), 32'h1);
    chk("t1_err", 32'(er), 32'd0);
    chk("t1_lat", 32'(lat), 32'd1);
    chk("t1_empty", 32'(bus.empty), 32'd0);
    do_txn(1, 1'b1, 8'h00, g, rv, er, rd, lat);
    chk("t2_gnt", 32'(g), 32'h2);
    chk("t2_rvalid", 32'(rv), 32'd1);
    chk("t2_rdata", 32'(rd), 32'hA5);
    chk("t2_err", 32'(er), 32'd0);
    chk("t2_empty", 32'(bus.empty), 32'd1);

    // Both requesters hold push requests for four transactions.
    begin
      int  nxt;
      bit  seen;
      @(negedge clk);
      bus.op     = 2'b00;
      bus.wdata0 = 8'd0;
      bus.wdata1 = 8'd1;
      bus.req    = 2'b11;
      nxt        = 2;
      for (int t = 0; t < 4; t++) begin
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
          @(negedge clk);
          if (bus.gnt != 2'b00) begin
            seen = 1'b1;
            break;
          end
        end
        if (!seen) chk("hold_timeout", 32'd0, 32'd1);
`ifdef LIFO_ARB_FIXED_PRIO_EN
        chk("hold_gnt", 32'(bus.gnt), 32'h1);
`else
        chk("hold_gnt", 32'(bus.gnt), (t % 2 == 1) ? 32'h2 : 32'h1);
`endif
        if (bus.gnt[1]) begin
          pushed[t]  = bus.wdata1;
          bus.wdata1 = 8'(nxt);
        end else begin
          pushed[t]  = bus.wdata0;
          bus.wdata0 = 8'(nxt);
        end
        nxt++;
      end
      bus.req = 2'b00;
      for (int t = 0; t < 4; t++) begin
        do_txn(t % 2, 1'b1, 8'h00, g, rv, er, rd, lat);
        chk("hold_pop", 32'(rd), 32'(pushed[3-t]));
`ifndef LIFO_ARB_FIXED_PRIO_EN
        chk("hold_pop_lit", 32'(rd), 32'(3 - t));
`endif
      end
    end

    // Fill to full, overflow, pop, drain, then underflow.
    for (int k = 0; k < DEPTH; k++) begin
      do_txn(0, 1'b0, 8'(8'h10 + k), g, rv, er, rd, lat);
    end
    chk("fill_full", 32'(bus.full), 32'd1);
    do_txn(0, 1'b0, 8'hEE, g, rv, er, rd, lat);
    chk("ovf_gnt", 32'(g), 32'h1);
    chk("ovf_err", 32'(er), 32'd1);
    chk("ovf_full", 32'(bus.full), 32'd1);
    do_txn(1, 1'b1, 8'h00, g, rv, er, rd, lat);
    chk("pfull_rdata", 32'(rd), 32'h1F);
    chk("pfull_rvalid", 32'(rv), 32'd1);
    chk("pfull_full", 32'(bus.full), 32'd0);
    for (int k = 0; k < DEPTH - 1; k++) begin
      do_txn(k % 2, 1'b1, 8'h00, g, rv, er, rd, lat);
      chk("drain_rdata", 32'(rd), 32'(8'h1E - k));
    end
    do_txn(0, 1'b1, 8'h00, g, rv, er, rd, lat);
    chk("udf_gnt", 32'(g), 32'h1);
    chk("udf_err", 32'(er), 32'd1);
    chk("udf_rvalid", 32'(rv), 32'd0);
    chk("udf_rdata", 32'(rd), 32'h10);
    chk("udf_empty", 32'(bus.empty), 32'd1);

    // Reset while a push is executing.
    @(negedge clk);
    bus.req[0] = 1'b1;
    bus.op[0]  = 1'b0;
    bus.wdata0 = 8'h77;
    @(negedge clk);
    resetn  = 1'b0;
    bus.req = 2'b00;
    #1;
    chk("mrst_gnt", 32'(bus.gnt), 32'd0);
    chk("mrst_empty", 32'(bus.empty), 32'd1);
    chk("mrst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("mrst_err", 32'(bus.err), 32'd0);
    chk("mrst_rdata", 32'(bus.rdata), 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("mrst_hold_gnt", 32'(bus.gnt), 32'd0);
    end
    resetn = 1'b1;
    do_txn(0, 1'b0, 8'h5A, g, rv, er, rd, lat);
    chk("post_rst_err", 32'(er), 32'd0);
    chk("post_rst_gnt", 32'(g), 32'h1);
    chk("post_rst_empty", 32'(bus.empty), 32'd0);
    do_txn(1, 1'b1, 8'h00, g, rv, er, rd, lat);
    chk("post_rst_pop", 32'(rd), 32'h5A);

    // Randomized traffic with alternating push-heavy and pop-heavy phases.
    for (int c = 0; c < 4000; c++) begin
      int pct;
      @(negedge clk);
      pct = ((c / 300) % 2 == 0) ? 80 : 25;
      for (int i = 0; i < 2; i++) begin
        bit raise;
        raise = 1'b0;
        if (bus.req[i] && bus.gnt[i]) begin
          if ($urandom_range(3) == 0) bus.req[i] = 1'b0;
          else raise = 1'b1;
        end else if (!bus.req[i] && $urandom_range(2) == 0) begin
          raise = 1'b1;
        end
        if (raise) begin
          bus.req[i] = 1'b1;
          bus.op[i]  = ($urandom_range(99) < pct) ? 1'b0 : 1'b1;
          if (i == 0) bus.wdata0 = 8'($urandom);
          else        bus.wdata1 = 8'($urandom);
        end
      end
    end
    @(negedge clk);
    bus.req = 2'b00;
    repeat (6) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lifo_arb.md
Name: lifo_arb

Overview:
- Two-requester arbiter and sequencer in front of a single shared 8-bit x16 LIFO stack.
- Each requester issues push or pop transactions over a req/gnt handshake.
- The block picks a winner with round-robin arbitration and executes the operation on the stack core.
- It returns pop data and an error flag, and exports full/empty status to the surrounding datapath.

Parameters:
- DW, 8: data width of stack entries and requester data.
- DEPTH, 16: number of stack entries. Must be a power of two and at least 2.
- AW, $clog2(DEPTH): address width. The stack pointer is AW+1 bits.

Ports:
- clk  input  1  single clock, rising edge
- resetn  input  1  asynchronous active-low reset
- req  input  2  per-requester request; held high until gnt
- op  input  2  per-requester operation, 0=push, 1=pop; stable while req high
- wdata0  input  DW  requester 0 push data; stable while req[0] high
- wdata1  input  DW  requester 1 push data; stable while req[1] high
- gnt  output  2  one-cycle completion pulse to the served requester (one-hot or zero)
- rvalid  output  1  pulses with gnt when a pop succeeded
- rdata  output  DW  popped data; valid when rvalid=1, holds last value otherwise
- err  output  1  pulses with gnt when a push hit full or a pop hit empty (operation dropped)
- full  output  1  stack pointer == DEPTH
- empty  output  1  stack pointer == 0

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE, pointer=0, rr_last=1 (so requester 0 wins first).
  - gnt, rvalid, err and rdata all 0; full=0, empty=1.
  - Stack memory is not cleared.
- Reset asserted mid-transaction aborts it: no gnt is issued and the pointer returns to 0.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - If req!=0, pick the winner, latch its index, op and wdata, then go to EXEC.
  - Otherwise stay in IDLE.
- Round-robin rule:
  - If both requesters request, the winner is the one not equal to rr_last.
  - If only one requests, it wins.
  - rr_last is updated to the winner in DONE.
- EXEC, push:
  - If not full: mem[ptr[AW-1:0]] <= data, ptr <= ptr+1.
  - Else set the err flag; no write.
- EXEC, pop:
  - If not empty: rdata <= mem[ptr-1], ptr <= ptr-1, set the ok flag.
  - Else set the err flag; rdata unchanged.
- EXEC always goes to DONE.
- DONE:
  - gnt[winner]=1 for exactly this cycle.
  - rvalid=1 if the pop succeeded; err=1 if the operation failed.
  - Go to IDLE.
- Latency: req rising in cycle N (sampled at edge N) gives gnt high in cycle N+2. A back-to-back transaction needs a minimum of 3 cycles.
- Requester protocol:
  - Drop req (or present a new op) on the edge that samples gnt=1.
  - A req still high in IDLE after its gnt is treated as a new request.
- req changes while the block is not in IDLE are ignored; the latched copy is used.
- full and empty are decoded combinationally from the registered pointer. They update the cycle after EXEC.
- Full-to-empty sequence: after DEPTH successful pushes full=1 and ptr=DEPTH. A further push gives err. A pop from full gives mem[DEPTH-1].

Optional Feature:
- Macro: LIFO_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; requester 0 always wins when both request, and rr_last is unused.
- Undefined (default): round-robin as specified above.

Decomposition:
- Package lifo_arb_pkg:
  - op encoding constants OP_PUSH=1'b0, OP_POP=1'b1.
  - FSM state encoding S_IDLE=2'd0, S_EXEC=2'd1, S_DONE=2'd2.
- One sub-module lifo_core:
  - Storage array plus pointer, with push/pop/din inputs and dout/full/empty outputs.
  - Async active-low reset of the pointer only.
  - The arbiter FSM drives lifo_core's push/pop for one cycle in EXEC.

Test Plan:
- Reset, then req=2'b01, op=0, wdata0=8'hA5 -> gnt=2'b01 two cycles later, err=0; empty goes 0.
- Then req=2'b10, op[1]=1 -> gnt=2'b10 with rvalid=1, rdata=8'hA5, err=0; empty=1.
- Both requesters hold push req continuously for 4 transactions (data 0..3) -> gnt alternates 01,10,01,10. A later sequence of 4 pops returns 3,2,1,0.
- 16 pushes of 8'h10..8'h1F -> full=1. The 17th push gives gnt plus err=1 and full stays 1. A pop returns 8'h1F and full=0.
- Pop while empty -> gnt with err=1, rvalid=0, rdata unchanged, pointer stays 0.
- Assert resetn=0 while in EXEC for a push -> no gnt, empty=1, outputs 0. After release the next push succeeds normally.
- With LIFO_ARB_FIXED_PRIO_EN defined, both requesters hold req -> requester 0 is granted every time.
